mont_radix4_core: RTL and testbench
===================================

Name: mont_radix4_core

Overview:
- Radix-4 Montgomery multiplication datapath and controller, directly downstream of the 2-bit operand shift register.
- Consumes one 2-bit digit a_i of operand A per iteration (LSB-first, taken from the shift register's low bits) and pulses digit_take to request the next shift.
- Iterates C <- (C + a_i*B + q_i*M)/4 for N_DIGITS iterations and presents C = A*B*4^-N mod M, range [0, 2M).
- Final conditional subtraction belongs to the next stage.

Parameters:
- WIDTH, 1028, operand/result width in bits (1024-bit modulus plus guard bits).
- N_DIGITS, 514, number of radix-4 iterations (= WIDTH/2).
- CNT_W, 10, width of the iteration counter; must satisfy 2^CNT_W > N_DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- restn  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- in_b  input  WIDTH  multiplicand B; latched when start is accepted.
- in_m  input  WIDTH  modulus M, odd; latched when start is accepted.
- digit  input  2  current digit a_i (shift register out_shift[1:0]).
- digit_valid  input  1  digit is valid (the shift register's done/valid indication).
- digit_take  output  1  one-cycle pulse when a digit is consumed; drives the shift register's shift input.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  final C; stable from done until the next accepted start.

Behaviour:
- Reset (restn=0, asynchronous): state=IDLE; C, B, M, B3, M3 and counter cleared; busy=0, done=0, digit_take=0, result=0. Reset mid-operation aborts the operation immediately with no partial result. Operation resumes after reset release only on a new start.
- Internal registers (C, B3, M3 and the adder) are WIDTH+2 bits wide; all sums are unsigned with no overflow for M < 2^(WIDTH-2). result = C[WIDTH-1:0].
- m' = (4 - M[1:0]) mod 4, derived combinationally from the latched M. It is valid because M is odd, so M^-1 mod 4 = M mod 4.
- States:
  - IDLE: busy=0. start=1 latches in_b and in_m, sets C=0, counter=0, goes to PRE_B3.
  - PRE_B3: B3 <- B + 2B; go to PRE_M3.
  - PRE_M3: M3 <- M + 2M; go to WAIT_DIGIT.
  - WAIT_DIGIT: stays while digit_valid=0. When digit_valid=1: T <- C + sel(a_i) with sel = 0, B, 2B, B3; digit_take=1 for this cycle only; go to ADD_M.
  - ADD_M: q = (T[1:0]*m') mod 4; C <- (T + sel(q)) >> 2 with sel = 0, M, 2M, M3. The low 2 bits are always 00 and are dropped. counter++. If counter reaches N_DIGITS go to DONE, else go to WAIT_DIGIT.
  - DONE: done=1 for exactly one cycle; result updated; go to IDLE.
- Latency: with digit_valid held high, done asserts 2 + 2*N_DIGITS cycles after the start-sampling edge.
- digit is sampled only in the cycle digit_take is high. The upstream stage has at least one cycle (ADD_M) to present the next digit.
- Edge conditions:
  - start while busy: ignored.
  - start and digit_valid high in IDLE: digit ignored.
  - digit_valid dropping in WAIT_DIGIT: stall with no state change.
  - A=0: result 0.
  - B=0: result 0.

Test Plan:
- WIDTH=12, N_DIGITS=4, M=13, B=7, A=5 (digits 01,01,00,00), digit_valid tied high -> digit_take pulses exactly 4 times; intermediate C=5,3,4,1; done 10 cycles after start; result=1.
- Same config, M=13, B=12, A=12 (digits 00,11,00,00) -> intermediate C=0,9,12,3; result=3 (check: 144*256^-1 mod 13 = 3).
- Same config, A=0, B=7, M=13 -> result=0. Then drop digit_valid for 5 cycles before digit 2 -> state frozen, no digit_take pulses during the stall, done delayed by exactly 5 cycles.
- Pulse start mid-operation (busy=1) -> ignored; in_b/in_m changes after acceptance do not affect result (still 1 for the first test vector).
- Assert restn=0 asynchronously between clock edges during iteration 2 -> busy, done, digit_take and result go to 0 immediately. After release, a new start with the first test vector yields result=1.
- Default WIDTH=1028, random odd 1024-bit M and random A, B < M, compared against a reference model -> result ≡ A*B*4^-514 mod M, result < 2M; done 1030 cycles after start.

Source files
------------

// File: rtl/mont_radix4_core.sv
// rtl/mont_radix4_core.sv - radix-4 Montgomery multiplier datapath and controller
// Output C = A*B*4^-N_DIGITS mod M in [0, 2M); final subtraction is done downstream.
module mont_radix4_core #(
   parameter int WIDTH    = 1028,
   parameter int N_DIGITS = 514,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             restn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   input  logic [1:0]       digit,
   input  logic             digit_valid,
   output logic             digit_take,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int IW = WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE_B3,
      S_PRE_M3,
      S_WAIT_DIGIT,
      S_ADD_M,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     c_q, t_q, b_q, m_q, b3_q, m3_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WIDTH-1:0]  res_q;
   logic [1:0]        m_prime, q;
   logic [IW-1:0]     sel_b, sel_m, sum_m, c_d;
   logic              last;

   // M is odd, so -M^-1 mod 4 reduces to -M mod 4
   assign m_prime = 2'd0 - m_q[1:0];
   assign q       = t_q[1:0] * m_prime;
   assign last    = (cnt_q == CNT_W'(N_DIGITS - 1));

   always_comb begin
      sel_b = '0;
      case (digit)
         2'd1:    sel_b = b_q;
         2'd2:    sel_b = b_q << 1;
         2'd3:    sel_b = b3_q;
         default: sel_b = '0;
      endcase
   end

   always_comb begin
      sel_m = '0;
      case (q)
         2'd1:    sel_m = m_q;
         2'd2:    sel_m = m_q << 1;
         2'd3:    sel_m = m3_q;
         default: sel_m = '0;
      endcase
   end

   // q is chosen so the low two bits of the sum are zero; the shift is exact
   assign sum_m = t_q + sel_m;
   assign c_d   = sum_m >> 2;

   always_ff @(posedge clk or negedge restn) begin
      if (!restn) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         t_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         b3_q    <= '0;
         m3_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  b_q   <= {2'b00, in_b};
                  m_q   <= {2'b00, in_m};
                  c_q   <= '0;
                  cnt_q <= '0;
               end
            end
            S_PRE_B3: b3_q <= b_q + (b_q << 1);
            S_PRE_M3: m3_q <= m_q + (m_q << 1);
            S_WAIT_DIGIT: begin
               if (digit_valid) t_q <= c_q + sel_b;
            end
            S_ADD_M: begin
               c_q   <= c_d;
               cnt_q <= cnt_q + 1'b1;
               if (last) res_q <= c_d[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (start) state_d = S_PRE_B3;
         S_PRE_B3:     state_d = S_PRE_M3;
         S_PRE_M3:     state_d = S_WAIT_DIGIT;
         S_WAIT_DIGIT: if (digit_valid) state_d = S_ADD_M;
         S_ADD_M:      state_d = last ? S_DONE : S_WAIT_DIGIT;
         S_DONE:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   assign digit_take = (state_q == S_WAIT_DIGIT) && digit_valid;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign result     = res_q;

endmodule

// File: tb/tb_mont_radix4_core.sv
// tb/tb_mont_radix4_core.sv - scoreboard bench for mont_radix4_core
// Small 12-bit instance with directed vectors plus a full-width instance against a radix-2 model.
module tb_mont_radix4_core;

   localparam int SW = 12;
   localparam int SN = 4;
   localparam int BW = 1028;
   localparam int BN = 514;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        restn;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input bit ok, input string nm, input logic [BW+1:0] act, input logic [BW+1:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // small instance
   logic          start_s, dv_s, take_s, busy_s, done_s;
   logic [SW-1:0] b_s, m_s, res_s, a_s, a_ld_s;

   always @(posedge clk) begin
      if (start_s && !busy_s) a_s <= a_ld_s;
      else if (take_s)        a_s <= a_s >> 2;
   end

   mont_radix4_core #(.WIDTH(SW), .N_DIGITS(SN), .CNT_W(3)) u_small (
      .clk(clk), .restn(restn), .start(start_s), .in_b(b_s), .in_m(m_s),
      .digit(a_s[1:0]), .digit_valid(dv_s), .digit_take(take_s),
      .busy(busy_s), .done(done_s), .result(res_s)
   );

   // full-width instance
   logic          start_b, take_b, busy_b, done_b;
   logic [BW-1:0] b_b, m_b, res_b, a_b, a_ld_b;

   always @(posedge clk) begin
      if (start_b && !busy_b) a_b <= a_ld_b;
      else if (take_b)        a_b <= a_b >> 2;
   end

   mont_radix4_core u_big (
      .clk(clk), .restn(restn), .start(start_b), .in_b(b_b), .in_m(m_b),
      .digit(a_b[1:0]), .digit_valid(1'b1), .digit_take(take_b),
      .busy(busy_b), .done(done_b), .result(res_b)
   );

   logic [SW-1:0]   exp_res_q[$];
   int unsigned     exp_cyc_q[$];
   logic [BW+1:0]   exp_big_q[$];
   int unsigned     exp_bcyc_q[$];
   int unsigned     s_cyc;

   initial begin : mon_small
      int          takes;
      logic [SW-1:0] er;
      int unsigned ec;
      takes = 0;
      forever begin
         @(negedge clk);
         if (!restn) takes = 0;
         else begin
            if (take_s) takes++;
            if (done_s) begin
               if (exp_res_q.size() == 0) chk(1'b0, "spurious_done", res_s, 0);
               else begin
                  er = exp_res_q.pop_front();
                  ec = exp_cyc_q.pop_front();
                  chk(res_s == er, "result", res_s, er);
                  chk(cyc == ec, "done_cycle", cyc, ec);
                  chk(takes == SN, "take_count", takes, SN);
               end
               takes = 0;
            end
         end
      end
   end

   initial begin : mon_big
      logic [BW+1:0] x;
      int unsigned   ec;
      forever begin
         @(negedge clk);
         if (restn && done_b) begin
            if (exp_big_q.size() == 0) chk(1'b0, "big_spurious_done", res_b, 0);
            else begin
               x  = exp_big_q.pop_front();
               ec = exp_bcyc_q.pop_front();
               chk(({2'b00, res_b} == x) || ({2'b00, res_b} == x + {2'b00, m_b}), "big_result", res_b, x);
               chk({2'b00, res_b} < ({2'b00, m_b} << 1), "big_range", res_b, {2'b00, m_b} << 1);
               chk(cyc == ec, "big_done_cycle", cyc, ec);
            end
         end
      end
   end

   // A*B mod M by double-and-add, then 2*BN exact halvings: result in [0, M)
   function automatic logic [BW+1:0] ref_mont(input logic [BW-1:0] a, b, m);
      logic [BW+1:0] y, mm, bb;
      mm = {2'b00, m};
      bb = {2'b00, b};
      y  = '0;
      for (int i = BW - 1; i >= 0; i--) begin
         y = y << 1;
         if (y >= mm) y = y - mm;
         if (a[i]) begin
            y = y + bb;
            if (y >= mm) y = y - mm;
         end
      end
      for (int i = 0; i < 2 * BN; i++) begin
         if (y[0]) y = y + mm;
         y = y >> 1;
      end
      return y;
   endfunction

   task automatic start_small(input logic [SW-1:0] a, b, m);
      @(negedge clk);
      a_ld_s  = a;
      b_s     = b;
      m_s     = m;
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      s_cyc   = cyc;
   endtask

   task automatic wait_takes(input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < 40 && seen < n; k++) begin
         @(negedge clk);
         if (take_s) seen++;
      end
      if (seen < n) chk(1'b0, "take_timeout", seen, n);
   endtask

   task automatic wait_done_small();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
         @(negedge clk);
         if (done_s) got = 1'b1;
      end
      if (!got) chk(1'b0, "done_timeout", 0, 1);
   endtask

   task automatic run_small(input logic [SW-1:0] a, b, m, exp, input int stall);
      start_small(a, b, m);
      exp_res_q.push_back(exp);
      exp_cyc_q.push_back(s_cyc + 10 + stall);
      if (stall > 0) begin
         wait_takes(1);
         @(posedge clk);
         #1;
         dv_s = 1'b0;
         for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            chk(take_s == 1'b0, "stall_take", take_s, 0);
            @(posedge clk);
         end
         #1;
         dv_s = 1'b1;
      end
      wait_done_small();
   endtask

   task automatic run_big();
      logic [BW-1:0] a, b, m;
      bit got;
      for (int k = 0; k < BW / 32 + 1; k++) begin
         if (32 * k < BW)       m[32*k +: 1] = 1'b0;
      end
      for (int k = 0; k < 32; k++) begin
         m[32*k +: 32] = $urandom;
         a[32*k +: 32] = $urandom;
         b[32*k +: 32] = $urandom;
      end
      m[BW-1:1024] = '0;
      a[BW-1:1023] = '0;
      b[BW-1:1023] = '0;
      m[1023]      = 1'b1;
      m[0]         = 1'b1;
      @(negedge clk);
      a_ld_b  = a;
      b_b     = b;
      m_b     = m;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      exp_bcyc_q.push_back(cyc + 2 + 2 * BN);
      exp_big_q.push_back(ref_mont(a, b, m));
      got = 1'b0;
      for (int k = 0; k < 1200 && !got; k++) begin
         @(negedge clk);
         if (done_b) got = 1'b1;
      end
      if (!got) chk(1'b0, "big_done_timeout", 0, 1);
   endtask

   initial begin
      restn   = 1'b0;
      start_s = 1'b0;
      start_b = 1'b0;
      dv_s    = 1'b1;
      a_ld_s  = '0;
      b_s     = '0;
      m_s     = '0;
      a_ld_b  = '0;
      b_b     = '0;
      m_b     = '0;
      repeat (3) @(negedge clk);
      chk(busy_s == 1'b0, "reset_busy", busy_s, 0);
      chk(done_s == 1'b0, "reset_done", done_s, 0);
      chk(take_s == 1'b0, "reset_take", take_s, 0);
      chk(res_s == '0, "reset_result", res_s, 0);
      #2 restn = 1'b1;

      run_small(12'd5,  12'd7,  12'd13, 12'd1, 0);
      run_small(12'd12, 12'd12, 12'd13, 12'd3, 0);
      run_small(12'd5,  12'd0,  12'd13, 12'd0, 0);
      run_small(12'd0,  12'd7,  12'd13, 12'd0, 5);

      // a start pulse and operand changes after acceptance must be ignored
      start_small(12'd5, 12'd7, 12'd13);
      exp_res_q.push_back(12'd1);
      exp_cyc_q.push_back(s_cyc + 10);
      repeat (3) @(negedge clk);
      start_s = 1'b1;
      b_s     = 12'd11;
      m_s     = 12'd9;
      a_ld_s  = 12'd0;
      @(negedge clk);
      start_s = 1'b0;
      wait_done_small();

      // asynchronous abort during iteration 2
      start_small(12'd5, 12'd7, 12'd13);
      wait_takes(2);
      #2 restn = 1'b0;
      #1;
      chk(busy_s == 1'b0, "abort_busy", busy_s, 0);
      chk(done_s == 1'b0, "abort_done", done_s, 0);
      chk(take_s == 1'b0, "abort_take", take_s, 0);
      chk(res_s == '0, "abort_result", res_s, 0);
      @(negedge clk);
      #2 restn = 1'b1;
      run_small(12'd5, 12'd7, 12'd13, 12'd1, 0);

      run_big();
      run_big();

      repeat (3) @(negedge clk);
      chk(exp_res_q.size() == 0, "small_queue_drained", exp_res_q.size(), 0);
      chk(exp_big_q.size() == 0, "big_queue_drained", exp_big_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
